// File: rtl/cast_int_to_float_seq_pkg.sv
// Shared FPU definitions for the integer-to-single converter: float field widths,
// rounding-mode encodings and converter FSM state encoding.
package cast_int_to_float_seq_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned FLT_W    = 1 + EXP_W + MAN_W;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cast_int_to_float_seq_if.sv
// Operand and result handshakes of the integer-to-float converter.
interface cast_int_to_float_seq_if
  import cast_int_to_float_seq_pkg::*;
#(
  parameter int unsigned IN_BITS = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [IN_BITS-1:0] in;
  logic               is_signed;
  logic [1:0]         rmode;
  logic               out_valid;
  logic               out_ready;
  logic [FLT_W-1:0]   out;
  logic               inexact;

  modport master (
    output in_valid, in, is_signed, rmode, out_ready,
    input  in_ready, out_valid, out, inexact
  );

  modport slave (
    input  in_valid, in, is_signed, rmode, out_ready,
    output in_ready, out_valid, out, inexact
  );

endinterface

// File: rtl/round_mode_unit.sv
// Applies one of four rounding modes to a truncated mantissa given guard/sticky bits.
module round_mode_unit
  import cast_int_to_float_seq_pkg::*;
(
  input  logic [MAN_W-1:0] mant,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  logic [1:0]       rmode,
  output logic [MAN_W-1:0] mant_rnd_c,
  output logic             carry_c,
  output logic             inexact_c
);

  logic inc_c;

  always_comb begin
    inc_c = 1'b0;
    case (rmode)
      RM_RNE: inc_c = guard & (sticky | mant[0]);
      RM_RTZ: inc_c = 1'b0;
      RM_RUP: inc_c = (guard | sticky) & ~sign;
      RM_RDN: inc_c = (guard | sticky) & sign;
    endcase
  end

  // Carry-out wraps the mantissa to zero; the caller bumps the exponent.
  assign {carry_c, mant_rnd_c} = {1'b0, mant} + {{MAN_W{1'b0}}, inc_c};
  assign inexact_c             = guard | sticky;

endmodule

// File: rtl/signed_compliment.sv
// Two's complement negation of a W-bit vector.
module signed_compliment #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] neg_c
);

  assign neg_c = ~value + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/cast_int_to_float_seq.sv
// Multi-cycle integer to IEEE-754 single converter: iterative normalisation,
// selectable rounding, one operand in flight.
module cast_int_to_float_seq
  import cast_int_to_float_seq_pkg::*;
#(
  parameter int unsigned IN_BITS    = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input logic                    clk,
  input logic                    clr,
  cast_int_to_float_seq_if.slave bus
);

  localparam int unsigned FRAC_W  = IN_BITS - 1 + MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + IN_BITS - 1);

  state_t             state;
  logic               sign_q;
  logic [1:0]         rmode_q;
  logic [IN_BITS-1:0] mag_q;
  logic [EXP_W-1:0]   exp_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [FLT_W-1:0]   out_q;
  logic               inexact_q;

  // One extra bit so the signed minimum negates to its true magnitude.
  logic               in_sign_c;
  logic [IN_BITS:0]   in_ext_c;
  logic [IN_BITS:0]   in_neg_c;
  logic [IN_BITS:0]   in_mag_c;

  assign in_sign_c = bus.in[IN_BITS-1] & bus.is_signed;
  assign in_ext_c  = {in_sign_c, bus.in};
  assign in_mag_c  = in_sign_c ? in_neg_c : in_ext_c;

  signed_compliment #(.W(IN_BITS + 1)) u_neg (
    .value (in_ext_c),
    .neg_c (in_neg_c)
  );

  // Fraction below the hidden bit, zero-padded so narrow inputs still yield mantissa and guard.
  logic [FRAC_W-1:0] frac_c;
  logic [MAN_W-1:0]  mant_c;
  logic              guard_c;
  logic              sticky_c;
  logic [MAN_W-1:0]  mant_rnd_c;
  logic              carry_c;
  logic              inexact_c;

  assign frac_c   = {mag_q[IN_BITS-2:0], {(MAN_W + 1){1'b0}}};
  assign mant_c   = frac_c[FRAC_W-1 -: MAN_W];
  assign guard_c  = frac_c[FRAC_W-MAN_W-1];
  assign sticky_c = |frac_c[FRAC_W-MAN_W-2:0];

  round_mode_unit u_round (
    .mant       (mant_c),
    .guard      (guard_c),
    .sticky     (sticky_c),
    .sign       (sign_q),
    .rmode      (rmode_q),
    .mant_rnd_c (mant_rnd_c),
    .carry_c    (carry_c),
    .inexact_c  (inexact_c)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      rmode_q     <= RM_RNE;
      mag_q       <= '0;
      exp_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      inexact_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            sign_q     <= in_sign_c;
            rmode_q    <= bus.rmode;
            mag_q      <= in_mag_c[IN_BITS-1:0];
            exp_q      <= EXP_INIT;
            if (in_mag_c == '0) begin
              out_q       <= '0;
              inexact_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[IN_BITS-1]) begin
            state <= ROUND;
          end else if (mag_q[IN_BITS-1 -: SHIFT_STEP] == '0) begin
            mag_q <= mag_q << SHIFT_STEP;
            exp_q <= exp_q - EXP_W'(SHIFT_STEP);
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - EXP_W'(1);
          end
        end
        ROUND: begin
          out_q       <= {sign_q, exp_q + {{(EXP_W-1){1'b0}}, carry_c}, mant_rnd_c};
          inexact_q   <= inexact_c;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.inexact   = inexact_q;

endmodule
